instruction_fetch_sequencer: RTL and testbench
==============================================

INSTRUCTION_FETCH_SEQUENCER -- requirements
Module: instruction_fetch_sequencer

Interface
REQ-001 SHALL have parameter RESET_PC, default 4'd0: program counter value loaded on reset.
REQ-002 SHALL have parameter SKIP_STEP, default 2: PC increment applied when a skip is taken.
REQ-003 SHALL have port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1: reset, synchronous and active-low.
REQ-005 SHALL have port run, input, 1: permission to start a new fetch.
REQ-006 SHALL have port rom_addr, output, 4: address to the program ROM (registered ROM, 1-cycle read latency).
REQ-007 SHALL have port rom_data, input, 4: opcode returned by the ROM one cycle after rom_addr.
REQ-008 SHALL have port instr, output, 4: issued opcode to the execute stage.
REQ-009 SHALL have port instr_valid, output, 1: instr and pc are valid.
REQ-010 SHALL have port instr_ready, input, 1: execute stage accepts instr this cycle.
REQ-011 SHALL have port pc, output, 4: ROM address of the issued instruction.
REQ-012 SHALL have port flag_a_nz, input, 1: register A non-zero, from execute.
REQ-013 SHALL have port flag_s_nz, input, 1: shift register S non-zero, from execute.
REQ-014 SHALL have port wrap, output, 1: one-cycle pulse when the PC wraps past 15.

Function
REQ-015 SHALL implement states FETCH, DECODE, ISSUE; rom_addr SHALL equal the PC register combinationally in all states.
REQ-016 FETCH: if run=1, go to DECODE next cycle; if run=0, stay in FETCH with PC held.
REQ-017 DECODE: capture rom_data into the instruction register; go to ISSUE next cycle; run is ignored.
REQ-018 ISSUE: instr_valid=1; instr and pc SHALL be held stable while instr_ready=0.
REQ-019 A handshake (instr_valid=1 and instr_ready=1) SHALL update the PC and return to FETCH on the same edge.
REQ-020 Latency from entering FETCH (with run=1) to instr_valid=1 SHALL be exactly 2 cycles; minimum throughput SHALL be one instruction per 3 cycles.
REQ-021 PC update SHALL be pc+1, or pc+SKIP_STEP when a skip is taken; arithmetic SHALL be modulo 16.
REQ-022 A skip SHALL be taken when instr=SNZA (4'b1000) with flag_a_nz=1, or instr=SNZS (4'b1001) with flag_s_nz=1; flags SHALL be sampled in the handshake cycle.
REQ-023 wrap SHALL pulse for one cycle, in the cycle after a handshake whose PC update carries out of bit 3 (e.g. 15->0, 14->0 on skip, 15->1 on skip).
REQ-024 instr_valid SHALL be 0 in FETCH and DECODE.
REQ-025 Deasserting run during DECODE or ISSUE SHALL NOT cancel the in-flight instruction.

Reset
REQ-026 When rst_n=0 at a rising edge: state=FETCH, PC=RESET_PC, instr=4'b0111 (CLR), instr_valid=0, wrap=0.
REQ-027 Reset SHALL take priority over a simultaneous handshake; the PC SHALL NOT advance.
REQ-028 Reset asserted mid-operation SHALL discard the pending instruction; fetch SHALL restart at RESET_PC.

Configuration
REQ-029 Macro FETCH_SKIP_EN defined: skip logic per REQ-022.
REQ-030 Macro FETCH_SKIP_EN undefined: SNZA/SNZS SHALL issue as ordinary opcodes; the PC SHALL always advance by 1; flag inputs SHALL be unused.

Structure
REQ-031 The opcode constants (LDA, LDB, LDO, LDSA, LDSB, LSH, RSH, CLR, SNZA, SNZS, ADD, SUB, XOR), the state encoding and the 4-bit PC width SHALL live in the shared package isa_pkg.
REQ-032 The PC next-value and wrap logic SHALL be the sub-module pc_next_calc; the FSM stays in the top module.

Verification
REQ-033 Reset, then run=1 with instr_ready tied to 1 -> instr_valid first rises 2 cycles after reset release; pc sequence 0,1,2,... with a 3-cycle spacing.
REQ-034 ROM addr 6=SNZA with flag_a_nz=1 (FETCH_SKIP_EN defined) -> pc after 6 is 8; with flag_a_nz=0 -> 7; with the macro undefined -> 7 in both cases.
REQ-035 instr_ready held 0 for 5 cycles in ISSUE -> instr and pc unchanged for all 5 cycles; exactly one PC increment after ready rises.
REQ-036 Run through addr 15 (opcode CLR) -> next pc 0 and wrap=1 for exactly one cycle; SNZS at addr 14 with flag_s_nz=1 -> next pc 0 and wrap=1.
REQ-037 rst_n=0 during ISSUE at pc=5 with instr_ready=1 -> next cycle pc=0, instr=4'b0111, instr_valid=0.
REQ-038 run=0 after reset -> rom_addr stays 0 and instr_valid stays 0 indefinitely; run=0 during DECODE -> the instruction still issues, then the block holds in FETCH.

Source files
------------

// File: rtl/isa_pkg.sv
// ============================================================================
// isa_pkg : opcodes, fetch-state encoding and PC width for the fetch sequencer
// Revision: 1.0
// ============================================================================
`default_nettype none

package isa_pkg;

   localparam int PC_W = 4;

   localparam logic [3:0] LDA  = 4'b0000;
   localparam logic [3:0] LDB  = 4'b0001;
   localparam logic [3:0] LDO  = 4'b0010;
   localparam logic [3:0] LDSA = 4'b0011;
   localparam logic [3:0] LDSB = 4'b0100;
   localparam logic [3:0] LSH  = 4'b0101;
   localparam logic [3:0] RSH  = 4'b0110;
   localparam logic [3:0] CLR  = 4'b0111;
   localparam logic [3:0] SNZA = 4'b1000;
   localparam logic [3:0] SNZS = 4'b1001;
   localparam logic [3:0] ADD  = 4'b1010;
   localparam logic [3:0] SUB  = 4'b1011;
   localparam logic [3:0] XOR  = 4'b1100;

   typedef enum logic [1:0] {
      FETCH  = 2'd0,
      DECODE = 2'd1,
      ISSUE  = 2'd2
   } state_t;

   function automatic logic is_skip(input logic [3:0] op, input logic a_nz, input logic s_nz);
      return ((op == SNZA) && a_nz) || ((op == SNZS) && s_nz);
   endfunction

endpackage

`default_nettype wire

// File: rtl/pc_next_calc.sv
// ============================================================================
// pc_next_calc : next-PC adder (modulo 2**PC_W) with carry-out for wrap.
// Macro FETCH_SKIP_EN enables conditional skip by SKIP_STEP.  Revision: 1.0
// ============================================================================
`default_nettype none

module pc_next_calc
   import isa_pkg::*;
#(
   parameter int SKIP_STEP = 2
) (
   input  logic [PC_W-1:0] pc,
   input  logic [3:0]      instr,
   input  logic            flag_a_nz,
   input  logic            flag_s_nz,
   output logic [PC_W-1:0] pc_next,
   output logic            carry
);

   logic [PC_W:0] step;
   logic [PC_W:0] sum;

`ifdef FETCH_SKIP_EN
   assign step = is_skip(instr, flag_a_nz, flag_s_nz) ? (PC_W+1)'(SKIP_STEP) : (PC_W+1)'(1);
`else
   logic unused_inputs;
   assign unused_inputs = ^{instr, flag_a_nz, flag_s_nz};
   assign step          = (PC_W+1)'(1);
`endif

   // The extra top bit of the sum is the carry out of bit PC_W-1.
   assign sum     = {1'b0, pc} + step;
   assign pc_next = sum[PC_W-1:0];
   assign carry   = sum[PC_W];

endmodule

`default_nettype wire

// File: rtl/instruction_fetch_sequencer.sv
// ============================================================================
// instruction_fetch_sequencer : FETCH/DECODE/ISSUE fetch FSM over a registered
// ROM. Optional macro FETCH_SKIP_EN enables SNZA/SNZS skips.  Revision: 1.0
// ============================================================================
`default_nettype none

module instruction_fetch_sequencer
   import isa_pkg::*;
#(
   parameter logic [PC_W-1:0] RESET_PC  = 4'd0,
   parameter int              SKIP_STEP = 2
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            run,
   output logic [PC_W-1:0] rom_addr,
   input  logic [3:0]      rom_data,
   output logic [3:0]      instr,
   output logic            instr_valid,
   input  logic            instr_ready,
   output logic [PC_W-1:0] pc,
   input  logic            flag_a_nz,
   input  logic            flag_s_nz,
   output logic            wrap
);

   state_t          state_q, state_d;
   logic [PC_W-1:0] pc_q, pc_d;
   logic [3:0]      instr_q, instr_d;
   logic            valid_q, valid_d;
   logic            wrap_q, wrap_d;

   logic [PC_W-1:0] pc_next;
   logic            pc_carry;

   pc_next_calc #(
      .SKIP_STEP (SKIP_STEP)
   ) u_pc_next_calc (
      .pc        (pc_q),
      .instr     (instr_q),
      .flag_a_nz (flag_a_nz),
      .flag_s_nz (flag_s_nz),
      .pc_next   (pc_next),
      .carry     (pc_carry)
   );

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      instr_d = instr_q;
      valid_d = valid_q;
      wrap_d  = 1'b0;
      case (state_q)
         FETCH: begin
            valid_d = 1'b0;
            if (run) begin
               state_d = DECODE;
            end
         end
         DECODE: begin
            // rom_data here reflects the address presented during FETCH.
            instr_d = rom_data;
            valid_d = 1'b1;
            state_d = ISSUE;
         end
         ISSUE: begin
            if (instr_ready) begin
               pc_d    = pc_next;
               wrap_d  = pc_carry;
               valid_d = 1'b0;
               state_d = FETCH;
            end
         end
         default: begin
            valid_d = 1'b0;
            state_d = FETCH;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= FETCH;
         pc_q    <= RESET_PC;
         instr_q <= CLR;
         valid_q <= 1'b0;
         wrap_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         instr_q <= instr_d;
         valid_q <= valid_d;
         wrap_q  <= wrap_d;
      end
   end

   assign rom_addr    = pc_q;
   assign pc          = pc_q;
   assign instr       = instr_q;
   assign instr_valid = valid_q;
   assign wrap        = wrap_q;

endmodule

`default_nettype wire

// File: tb/tb_instruction_fetch_sequencer.sv
// ============================================================================
// tb_instruction_fetch_sequencer : randomized bench with a transaction-level
// model of the fetch sequencer (honours FETCH_SKIP_EN).  Revision: 1.0
// ============================================================================
`default_nettype none

module tb_instruction_fetch_sequencer;

   localparam logic [3:0] RESET_PC  = 4'd0;
   localparam int         SKIP_STEP = 2;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       run;
   logic [3:0] rom_addr;
   logic [3:0] rom_data;
   logic [3:0] instr;
   logic       instr_valid;
   logic       instr_ready;
   logic [3:0] pc;
   logic       flag_a_nz;
   logic       flag_s_nz;
   logic       wrap;

   logic [3:0] rom [16];

   int total = 0;
   int bad   = 0;

   // Model: current PC, whether an instruction is on offer, wrap expectation,
   // and how many edges have elapsed since a fetch was granted (-1 = idle).
   int m_pc;
   bit m_issue;
   bit m_wrap;
   int m_since;

   always #5 clk = ~clk;

   always @(posedge clk) rom_data <= rom[rom_addr];

   instruction_fetch_sequencer #(
      .RESET_PC  (RESET_PC),
      .SKIP_STEP (SKIP_STEP)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .run         (run),
      .rom_addr    (rom_addr),
      .rom_data    (rom_data),
      .instr       (instr),
      .instr_valid (instr_valid),
      .instr_ready (instr_ready),
      .pc          (pc),
      .flag_a_nz   (flag_a_nz),
      .flag_s_nz   (flag_s_nz),
      .wrap        (wrap)
   );

   task automatic chk(input string tag, input int obs, input int exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   function automatic int step_of(input logic [3:0] op, input logic fa, input logic fs);
      int inc = 1;
`ifdef FETCH_SKIP_EN
      if ((op == 4'b1000 && fa) || (op == 4'b1001 && fs)) inc = SKIP_STEP;
`endif
      return inc;
   endfunction

   task automatic model_reset();
      m_pc    = RESET_PC;
      m_issue = 0;
      m_wrap  = 0;
      m_since = -1;
   endtask

   // Called at a falling edge: compare, drive the next inputs, advance the model.
   task automatic step_cycle(input logic r, input logic rdy, input logic fa, input logic fs);
      int inc;
      chk("valid", instr_valid, m_issue);
      chk("wrap", wrap, m_wrap);
      chk("rom_addr", rom_addr, m_pc);
      if (m_issue) begin
         chk("pc", pc, m_pc);
         chk("instr", instr, rom[m_pc]);
      end
      run         = r;
      instr_ready = rdy;
      flag_a_nz   = fa;
      flag_s_nz   = fs;
      m_wrap = 0;
      if (m_issue) begin
         if (rdy) begin
            inc     = step_of(rom[m_pc], fa, fs);
            m_wrap  = (m_pc + inc) > 15;
            m_pc    = (m_pc + inc) % 16;
            m_issue = 0;
            m_since = -1;
         end
      end else if (m_since >= 0) begin
         m_since++;
         if (m_since == 2) m_issue = 1;
      end else if (r) begin
         m_since = 1;
      end
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      @(negedge clk);
      @(negedge clk);
      model_reset();
      chk("rst_valid", instr_valid, 0);
      chk("rst_pc", pc, RESET_PC);
      chk("rst_instr", instr, 4'b0111);
      chk("rst_wrap", wrap, 0);
      rst_n = 1'b1;
   endtask

   initial begin
      bit found;
      rst_n       = 1'b0;
      run         = 1'b0;
      instr_ready = 1'b0;
      flag_a_nz   = 1'b0;
      flag_s_nz   = 1'b0;
      for (int i = 0; i < 16; i++) rom[i] = 4'($urandom_range(0, 12));
      rom[6]  = 4'b1000;
      rom[14] = 4'b1001;
      rom[15] = 4'b0111;

      do_reset();

      // Idle with run low: nothing must move.
      for (int i = 0; i < 10; i++)
         step_cycle(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));

      // Free-running: back-to-back issue with ready tied high, covering wraps and skips.
      for (int i = 0; i < 150; i++)
         step_cycle(1'b1, 1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));

      // Random run, ready and flags, including long stalls.
      for (int i = 0; i < 600; i++)
         step_cycle(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) == 0),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));

      // Reset while pc=5 is on offer with ready high: no advance, restart at RESET_PC.
      do_reset();
      found = 0;
      for (int i = 0; i < 100 && !found; i++) begin
         if (m_issue && m_pc == 5) found = 1;
         else step_cycle(1'b1, 1'b1, 1'b0, 1'b0);
      end
      chk("reach_pc5", found, 1);
      chk("pc5_valid", instr_valid, 1);
      chk("pc5_pc", pc, 5);
      rst_n       = 1'b0;
      instr_ready = 1'b1;
      @(negedge clk);
      chk("midrst_pc", pc, RESET_PC);
      chk("midrst_instr", instr, 4'b0111);
      chk("midrst_valid", instr_valid, 0);
      model_reset();
      rst_n = 1'b1;

      for (int i = 0; i < 400; i++)
         step_cycle(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

`default_nettype wire
